// File: rtl/fp32_pkg.sv
// fp32_pkg: shared single-precision field layout, constants, FSM states and helpers
package fp32_pkg;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  localparam int BIAS = 127;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;
  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;
  typedef enum logic [1:0] {CLS_ZERO, CLS_INF, CLS_NAN, CLS_NORM} cls_t;
  function automatic logic f_sign(input logic [31:0] x);
    return x[31];
  endfunction
  function automatic logic [EXP_W-1:0] f_exp(input logic [31:0] x);
    return x[30:23];
  endfunction
  function automatic logic [FRAC_W-1:0] f_frac(input logic [31:0] x);
    return x[22:0];
  endfunction
  // Denormals (exp=0, frac!=0) are flushed and classify as zero.
  function automatic cls_t classify(input logic [31:0] x);
    return f_exp(x) == '0 ? CLS_ZERO :
           f_exp(x) != '1 ? CLS_NORM :
           f_frac(x) == '0 ? CLS_INF : CLS_NAN;
  endfunction
endpackage

// File: rtl/sfpp_div_if.sv
// sfpp_div_if: start/done request bus of the divider with operands, quotient and flags
interface sfpp_div_if;
  logic start;
  logic [31:0] a;
  logic [31:0] b;
  logic busy;
  logic done;
  logic [31:0] result;
  logic dz;
  logic inv;
  logic ovf;
  logic unf;
  modport master (output start, a, b, input busy, done, result, dz, inv, ovf, unf);
  modport slave (input start, a, b, output busy, done, result, dz, inv, ovf, unf);
endinterface

// File: rtl/sfpp_mant_div.sv
// sfpp_mant_div: 24-bit radix-2 restoring mantissa divider producing a 25-bit quotient
module sfpp_mant_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [23:0] ma,
  input  logic [23:0] mb,
  output logic [24:0] q,
  output logic        last
);
  logic [24:0] r, rn;
  logic [23:0] mb_r;
  logic [4:0] cnt;
  logic ge;
  // trial subtraction; keep the remainder when the divisor does not fit
  always_comb begin
    ge = r >= {1'b0, mb_r};
    rn = ge ? r - {1'b0, mb_r} : r;
  end
  assign last = cnt == 5'd24;
  // load operands, then one quotient bit per step, MSB first
  always_ff @(posedge clk) begin
    if (rst) begin
      r <= '0;
      q <= '0;
      mb_r <= '0;
      cnt <= '0;
    end else if (load) begin
      r <= {1'b0, ma};
      q <= '0;
      mb_r <= mb;
      cnt <= '0;
    end else if (step) begin
      r <= rn << 1;
      q <= {q[23:0], ge};
      cnt <= cnt + 5'd1;
    end
  end
endmodule

// File: rtl/sfpp_div.sv
// sfpp_div: iterative single-precision divider with special-case handling and flush-to-zero
module sfpp_div
  import fp32_pkg::*;
(
  input logic clk,
  input logic rst,
  sfpp_div_if.slave bus
);
  state_t state, state_n;
  cls_t ca, cb;
  logic load, step, last, special, sgn, sgn_n;
  logic [24:0] q;
  logic [EXP_W-1:0] ea, eb;
  logic [31:0] result, spec_res;
  logic [3:0] spec_flags;
  logic dz, inv, ovf, unf, ovf_n, unf_n;
  logic signed [9:0] e;
  logic [FRAC_W-1:0] frac;
  sfpp_mant_div u_mant (
    .clk(clk),
    .rst(rst),
    .load(load),
    .step(step),
    .ma({1'b1, f_frac(bus.a)}),
    .mb({1'b1, f_frac(bus.b)}),
    .q(q),
    .last(last)
  );
  // classify incoming operands and pick the special result by priority
  always_comb begin
    ca = classify(bus.a);
    cb = classify(bus.b);
    sgn_n = f_sign(bus.a) ^ f_sign(bus.b);
    special = ca != CLS_NORM || cb != CLS_NORM;
    spec_res = {sgn_n, 31'h0};
    spec_flags = 4'b0000;
    if (ca == CLS_NAN || cb == CLS_NAN || (ca == CLS_ZERO && cb == CLS_ZERO) ||
        (ca == CLS_INF && cb == CLS_INF)) begin
      spec_res = QNAN;
      spec_flags = 4'b0100;
    end else if (ca == CLS_INF) begin
      spec_res = {sgn_n, POS_INF[30:0]};
    end else if (cb == CLS_ZERO) begin
      spec_res = {sgn_n, POS_INF[30:0]};
      spec_flags = 4'b1000;
    end
  end
  // normalise the quotient and range-check the biased exponent
  always_comb begin
    e = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127 - (q[24] ? 10'sd0 : 10'sd1);
    frac = q[24] ? q[23:1] : q[22:0];
    ovf_n = e >= 10'sd255;
    unf_n = e <= 10'sd0;
  end
  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // next state and divider controls
  always_comb begin
    state_n = state;
    load = 1'b0;
    step = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        state_n = special ? DONE : DIVIDE;
        load = !special;
      end
      DIVIDE: begin
        step = 1'b1;
        if (last) state_n = NORM;
      end
      NORM: state_n = DONE;
      default: state_n = IDLE;
    endcase
  end
  // capture operand fields on start; register result and flags entering DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      result <= '0;
      {dz, inv, ovf, unf} <= '0;
      sgn <= 1'b0;
      ea <= '0;
      eb <= '0;
    end else if (state == IDLE && bus.start) begin
      sgn <= sgn_n;
      ea <= f_exp(bus.a);
      eb <= f_exp(bus.b);
      {dz, inv, ovf, unf} <= special ? spec_flags : 4'b0000;
      if (special) result <= spec_res;
    end else if (state == NORM) begin
      result <= ovf_n ? {sgn, POS_INF[30:0]} : unf_n ? {sgn, 31'h0} : {sgn, e[7:0], frac};
      ovf <= ovf_n;
      unf <= unf_n && !ovf_n;
    end
  end
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign bus.result = result;
  assign bus.dz = dz;
  assign bus.inv = inv;
  assign bus.ovf = ovf;
  assign bus.unf = unf;
endmodule

// File: doc/sfpp_div.md
Name: sfpp_div

Overview:
- Iterative IEEE-754 single-precision floating-point divider, computing result = a / b.
- Companion to the team's single-precision multiplier; shares the same field layout:
  - bit 31 = sign
  - bits 30:23 = 8-bit biased exponent, bias 127
  - bits 22:0 = 23-bit fraction
- Multi-cycle start/done handshake using a radix-2 restoring mantissa divider.
- Sits beside the multiplier in the FP datapath, with one operation in flight at a time.

Parameters:
- EXP_W, 8, exponent field width.
- FRAC_W, 23, fraction field width.
- BIAS, 127, exponent bias.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- a  input  32  dividend, captured on accepted start
- b  input  32  divisor, captured on accepted start
- busy  output  1  high from accepted start until done cycle inclusive
- done  output  1  one-cycle pulse; result and flags valid
- result  output  32  quotient; held until the next accepted start
- dz  output  1  divide-by-zero flag, held with result
- inv  output  1  invalid-operation flag, held with result
- ovf  output  1  overflow flag, held with result
- unf  output  1  underflow flag, held with result

Behaviour:
- Interface: single clock clk; rst synchronous active-high.
- Reset:
  - State to IDLE.
  - busy=0, done=0, result=32'h0, all flags 0, iteration counter 0.
  - Reset mid-operation aborts the operation; no done is produced.
- States: IDLE, DIVIDE, NORM, DONE.
- IDLE:
  - start=1 at edge T captures a, b, clears the flags, sets busy=1.
  - Special operand → DONE at edge T. Otherwise → DIVIDE with count=0.
- Special classes:
  - exp=0 is zero; nonzero fraction with exp=0 is flushed to zero.
  - exp=255, frac=0 is inf; exp=255, frac≠0 is NaN.
- Special results (sign = sa^sb unless NaN). Priority order:
  1. NaN operand, 0/0, or inf/inf → 32'h7FC00000, inv=1.
  2. inf/x → signed inf.
  3. x/0 (x finite, nonzero) → signed inf, dz=1.
  4. 0/x or x/inf → signed zero.
- DIVIDE:
  - Operands: ma={1,fa}, mb={1,fb} (24 bits). Remainder R (25 bits) starts at ma.
  - Each cycle: if R>=mb then q bit=1 and R=R-mb, else q bit=0. Then R=R<<1 and q shifts in MSB-first.
  - Runs exactly 25 iterations (count 0..24), producing q[24:0]. After the 25th iteration → NORM.
- NORM:
  - q[24]=1: frac=q[23:1], e = ea - eb + BIAS.
  - Otherwise: frac=q[22:0], e = ea - eb + BIAS - 1.
  - e is computed signed, 10 bits.
  - Rounding is truncation (round toward zero); there is no sticky bit.
  - e>=255 → signed inf, ovf=1.
  - e<=0 → signed zero, unf=1 (flush to zero, no denormal output).
  - → DONE.
- DONE:
  - result and flags are registered on entry. done=1 for exactly one cycle, busy=1 in that cycle.
  - Next edge → IDLE with busy=0.
- Latency, counted from the start-sampling edge T:
  - Normal operands: done is high in the cycle after edge T+26.
  - Special operands: done is high in the cycle after edge T.
- start while busy=1 is ignored with no queueing; a and b may change freely during the operation.
- start held high in the DONE cycle is not accepted. It is accepted in the following IDLE cycle.

Decomposition:
- Shared package fp32_pkg:
  - EXP_W, FRAC_W, BIAS.
  - QNAN (32'h7FC00000), POS_INF (32'h7F800000).
  - State enum for IDLE/DIVIDE/NORM/DONE.
  - Field-extract functions for sign, exponent and fraction.
  - Operand classification function: zero / inf / nan / normal.
- One sub-module: sfpp_mant_div, the 24-bit restoring divider datapath (R/q registers, 25-step counter, load/step controls).
- The top level holds the FSM, exponent arithmetic, special-case logic and normalisation.

Test Plan:
- a=40C00000 (6.0), b=40000000 (2.0), start at edge T → result 40400000, done high after edge T+26, no flags set, busy low one cycle later.
- a=3F800000 (1.0), b=40400000 (3.0) → result 3EAAAAAA (truncated), no flags.
- a=BF800000, b=00000000 → result FF800000, dz=1, done after edge T. Then a=00000000, b=00000000 → 7FC00000, inv=1.
- a=7F000000, b=00800000 → result 7F800000, ovf=1. a=00800000, b=7F000000 → result 00000000, unf=1.
- Pulse start with a new operand pair at edges T+5 and T+26 of a running divide → both ignored, result is that of the original pair. start at the IDLE edge after done → accepted.
- Assert rst at edge T+10 of a divide → busy=0, done never pulses, result=0. A fresh start on 40C00000/40000000 afterwards → 40400000.
